instr_fetch: RTL and testbench

//  Upstream feeder for the 16-bit bus processor. Fetches each instruction word, plus the immediate
//  for mvi, from a synchronous program ROM and presents them on the processor's DIN. Drives Run and

---
 rtl/instr_fetch_pkg.sv | 43 ++++
 rtl/instr_fetch_if.sv | 38 +++
 rtl/instr_fetch_pc.sv | 43 ++++
 rtl/instr_fetch.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch unit that feeds the 16-bit
//   bus processor: opcode constants, FSM state encoding and small opcode
//   decode helpers.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int WORD_W = 16;

    // Opcode lives in the top three bits of every instruction word.
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_OP  = 3'd1,
        S_LD_OP  = 3'd2,
        S_RD_IMM = 3'd3,
        S_LD_IMM = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic [2:0] opcode(input logic [WORD_W-1:0] word);
        return word[15:13];
    endfunction

    // Opcodes the processor can actually execute.
    function automatic logic is_exec_op(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Anything that is neither executable nor halt (100..110).
    function automatic logic is_illegal(input logic [2:0] op);
        return !is_exec_op(op) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the fetch unit's ROM port, processor handshake and status lines.
//   Signals:
//     start     1-cycle start request (honoured in IDLE/HALT only)
//     done      processor Done, combinational in its last step
//     rom_data  synchronous ROM read data (one cycle after rom_addr)
//     rom_addr  ROM address
//     din       word driven onto the processor DIN bus
//     run       processor Run
//     pc        address of the current instruction word
//     halted    fetch unit stopped in HALT
//     error     sticky illegal-opcode flag
//   Modports: master = fetch unit, slave = processor/ROM/controller side.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int AW = 8
);
    logic          start;
    logic          done;
    logic [15:0]   rom_data;
    logic [AW-1:0] rom_addr;
    logic [15:0]   din;
    logic          run;
    logic [AW-1:0] pc;
    logic          halted;
    logic          error;

    modport master (
        input  start, done, rom_data,
        output rom_addr, din, run, pc, halted, error
    );

    modport slave (
        output start, done, rom_data,
        input  rom_addr, din, run, pc, halted, error
    );
endinterface

// File: rtl/instr_fetch_pc.sv
// -----------------------------------------------------------------------------
// instr_fetch_pc
//   Program counter for the fetch unit. AW bits, wraps modulo 2**AW.
//   Ports:
//     clk       rising-edge clock
//     rst       async active-high, clears PC to RESET_PC
//     load      reload RESET_PC (restart from HALT)
//     inc1      advance by one word
//     inc2      advance by two words (mvi: opcode + immediate)
//     pc        current instruction address
//     pc_plus1  address of the word after pc (immediate fetch)
// -----------------------------------------------------------------------------
module instr_fetch_pc #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc1,
    input  logic          inc2,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus1
);

    logic [AW-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= RESET_PC;
        end else if (inc2) begin
            pc_q <= pc_q + AW'(2);
        end else if (inc1) begin
            pc_q <= pc_q + AW'(1);
        end
    end

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + AW'(1);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Upstream feeder for the 16-bit bus processor. Reads each instruction
//   word (and the immediate for mvi) from a synchronous ROM, presents it on
//   the processor DIN, drives Run, and advances the PC when the processor
//   signals Done. Stops on halt or on an illegal opcode (sticky error).
//   Ports:
//     clk   rising-edge clock shared with the processor
//     rst   asynchronous active-high reset
//     bus   instr_fetch_if.master (start/done/rom/din/run/pc/halted/error)
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | after reset, waiting for start
//   RD_OP    | rom_addr = pc, opcode word being read
//   LD_OP    | opcode word on rom_data, latched, decoded
//   RD_IMM   | rom_addr = pc+1, immediate being read (mvi only)
//   LD_IMM   | immediate on rom_data, latched
//   EXEC     | run high; beat 0 drives opcode, later beats opcode or imm
//   HALT     | stopped on halt/illegal opcode, pc holds offending address
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.master bus
);

    state_t        state;
    state_t        state_nx;

    logic [15:0]   op_reg;
    logic [15:0]   imm_reg;
    logic          beat_late;   // 0 in the first EXEC cycle, 1 afterwards
    logic          run_q;
    logic          halted_q;
    logic          error_q;

    logic          pc_load;
    logic          pc_inc1;
    logic          pc_inc2;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] rom_addr;

    logic [2:0]    rd_op;
    logic          op_is_mvi;
    logic          start_ok;
    logic          ld_illegal;

    assign rd_op      = opcode(bus.rom_data);
    assign op_is_mvi  = (opcode(op_reg) == OP_MVI);
    assign start_ok   = bus.start && ((state == S_IDLE) || (state == S_HALT));
    assign ld_illegal = (state == S_LD_OP) && is_illegal(rd_op);

    instr_fetch_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .inc1     (pc_inc1),
        .inc2     (pc_inc2),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_load  = 1'b0;
        pc_inc1  = 1'b0;
        pc_inc2  = 1'b0;
        rom_addr = pc;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_RD_OP;
                end
            end
            S_RD_OP: begin
                state_nx = S_LD_OP;
            end
            S_LD_OP: begin
                if (!is_exec_op(rd_op)) begin
                    state_nx = S_HALT;
                end else if (rd_op == OP_MVI) begin
                    state_nx = S_RD_IMM;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_RD_IMM: begin
                rom_addr = pc_plus1;
                state_nx = S_LD_IMM;
            end
            S_LD_IMM: begin
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                // Done in beat 0 cannot be a real completion; ignore it.
                if (beat_late && bus.done) begin
                    state_nx = S_RD_OP;
                    pc_inc2  = op_is_mvi;
                    pc_inc1  = !op_is_mvi;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    state_nx = S_RD_OP;
                    pc_load  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Run/halted are registered from the next state so they line up exactly
    // with EXEC/HALT; run falls the cycle after Done, which lets the
    // processor's own clear hold its step counter at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg    <= '0;
            imm_reg   <= '0;
            beat_late <= 1'b0;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            if (state == S_LD_OP) begin
                op_reg <= bus.rom_data;
            end
            if (state == S_LD_IMM) begin
                imm_reg <= bus.rom_data;
            end
            beat_late <= (state == S_EXEC) && (state_nx == S_EXEC);
            run_q     <= (state_nx == S_EXEC);
            halted_q  <= (state_nx == S_HALT);
            if (ld_illegal) begin
                error_q <= 1'b1;
            end else if (start_ok) begin
                error_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.din = 16'h0000;
        if (state == S_EXEC) begin
            bus.din = (beat_late && op_is_mvi) ? imm_reg : op_reg;
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.run      = run_q;
    assign bus.pc       = pc;
    assign bus.halted   = halted_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.AW(8)) bus ();
    instr_fetch_if #(.AW(8)) bus2 ();

    instr_fetch #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_fetch #(.AW(8), .RESET_PC(8'hFF)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] rom  [256];
    logic [15:0] rom2 [256];

    always @(posedge clk) bus.rom_data  <= rom[bus.rom_addr];
    always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];

    // Processor stand-in: step counter cleared while Run is low, Done
    // asserted combinationally at step done_beat.
    int unsigned step, step2;
    int unsigned done_beat;
    logic        done_extra;

    always @(posedge clk or posedge rst) begin
        if (rst)           step <= 0;
        else if (!bus.run) step <= 0;
        else               step <= step + 1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst)            step2 <= 0;
        else if (!bus2.run) step2 <= 0;
        else                step2 <= step2 + 1;
    end

    assign bus.done  = (bus.run && (step == done_beat)) || done_extra;
    assign bus2.done = bus2.run && (step2 == done_beat);

    // Minimal register file: IR loaded in step 0, mvi writes its register in step 1.
    logic [15:0] ir;
    logic [15:0] regs [8];
    always @(posedge clk) begin
        if (bus.run) begin
            if (step == 0)
                ir <= bus.din;
            else if (step == 1 && ir[15:13] == 3'b001)
                regs[ir[12:10]] <= bus.din;
        end
    end

    logic [15:0] din_log [16];
    int          nlog;

    task automatic clear_roms();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 16'hE000;
            rom2[i] = 16'hE000;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge of the RD_OP cycle.
    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic step_until_pc(input logic [7:0] target, input int budget, output int lat);
        lat  = 0;
        nlog = 0;
        while (bus.pc !== target && lat < budget) begin
            @(negedge clk);
            lat++;
            if (bus.run === 1'b1 && nlog < 16) begin
                din_log[nlog] = bus.din;
                nlog++;
            end
        end
    endtask

    task automatic run_to_halt(input int budget, output int run_cyc, output bit ok);
        run_cyc = 0;
        ok      = 1'b0;
        nlog    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1) begin
                run_cyc++;
                if (nlog < 16) begin
                    din_log[nlog] = bus.din;
                    nlog++;
                end
            end
            if (bus.halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_roms();
        apply_reset();
        checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL reset_run got %0h exp 0", bus.run); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h exp 00", bus.pc); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", bus.halted); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %0h exp 0", bus.error); end
        checks++; if (bus.din !== 16'h0000) begin errors++; $display("FAIL reset_din got %0h exp 0000", bus.din); end
        checks++; if (bus2.pc !== 8'hFF) begin errors++; $display("FAIL reset_pc2 got %0h exp ff", bus2.pc); end
    endtask

    task automatic test_mv();
        int lat, rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h0040;
        rom[1] = 16'hE000;
        done_beat = 1;
        apply_reset();
        start_pulse();
        step_until_pc(8'h01, 20, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL mv_latency got %0d exp 4", lat); end
        checks++; if (nlog !== 2) begin errors++; $display("FAIL mv_run_cycles got %0d exp 2", nlog); end
        checks++; if (din_log[0] !== 16'h0040) begin errors++; $display("FAIL mv_din0 got %0h exp 0040", din_log[0]); end
        checks++; if (din_log[1] !== 16'h0040) begin errors++; $display("FAIL mv_din1 got %0h exp 0040", din_log[1]); end
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mv_halt got %0h exp 1", ok); end
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL mv_halt_pc got %0h exp 01", bus.pc); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL mv_error got %0h exp 0", bus.error); end
        // Done outside EXEC must not move anything.
        done_extra = 1'b1;
        @(negedge clk);
        done_extra = 1'b0;
        @(negedge clk);
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL done_in_halt_pc got %0h exp 01", bus.pc); end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL done_in_halt_halted got %0h exp 1", bus.halted); end
    endtask

    task automatic test_mvi();
        int lat, rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h2800;
        rom[1] = 16'hBEEF;
        rom[2] = 16'hE000;
        done_beat = 1;
        apply_reset();
        start_pulse();
        step_until_pc(8'h02, 20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL mvi_latency got %0d exp 6", lat); end
        checks++; if (din_log[0] !== 16'h2800) begin errors++; $display("FAIL mvi_din_beat0 got %0h exp 2800", din_log[0]); end
        checks++; if (din_log[1] !== 16'hBEEF) begin errors++; $display("FAIL mvi_din_beat1 got %0h exp beef", din_log[1]); end
        checks++; if (regs[2] !== 16'hBEEF) begin errors++; $display("FAIL mvi_r2 got %0h exp beef", regs[2]); end
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mvi_halt got %0h exp 1", ok); end
        checks++; if (bus.pc !== 8'h02) begin errors++; $display("FAIL mvi_halt_pc got %0h exp 02", bus.pc); end
    endtask

    task automatic test_add_long();
        int rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h4040;
        rom[1] = 16'hE000;
        done_beat = 3;
        apply_reset();
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL add_run_b0 got %0h exp 1", bus.run); end
        checks++; if (bus.din !== 16'h4040) begin errors++; $display("FAIL add_din_b0 got %0h exp 4040", bus.din); end
        done_extra = 1'b1;
        @(negedge clk);
        done_extra = 1'b0;
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL add_run_b1 got %0h exp 1", bus.run); end
        checks++; if (bus.din !== 16'h4040) begin errors++; $display("FAIL add_din_b1 got %0h exp 4040", bus.din); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL add_run_b2 got %0h exp 1", bus.run); end
        checks++; if (bus.din !== 16'h4040) begin errors++; $display("FAIL add_din_b2 got %0h exp 4040", bus.din); end
        @(negedge clk);
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL add_run_b3 got %0h exp 1", bus.run); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL add_pc_b3 got %0h exp 00", bus.pc); end
        @(negedge clk);
        checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL add_run_after got %0h exp 0", bus.run); end
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL add_pc_after got %0h exp 01", bus.pc); end
        checks++; if (bus.din !== 16'h0000) begin errors++; $display("FAIL add_din_after got %0h exp 0000", bus.din); end
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1 || bus.pc !== 8'h01) begin errors++; $display("FAIL add_halt ok %0h pc %0h exp ok 1 pc 01", ok, bus.pc); end
        done_beat = 1;
    endtask

    task automatic test_illegal();
        int rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h8000;
        done_beat = 1;
        apply_reset();
        start_pulse();
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ill_halt got %0h exp 1", ok); end
        checks++; if (rc !== 0) begin errors++; $display("FAIL ill_run_cycles got %0d exp 0", rc); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL ill_error got %0h exp 1", bus.error); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL ill_pc got %0h exp 00", bus.pc); end
        rom[0] = 16'hE000;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL ill_restart_error got %0h exp 0", bus.error); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL ill_restart_halted got %0h exp 0", bus.halted); end
        checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL ill_refetch_addr got %0h exp 00", bus.rom_addr); end
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL ill_rehalt ok %0h err %0h exp ok 1 err 0", ok, bus.error); end
    endtask

    task automatic test_wrap();
        int n;
        clear_roms();
        rom2[8'hFF] = 16'h2C00;
        rom2[8'h00] = 16'h1234;
        rom2[8'h01] = 16'hE000;
        done_beat = 1;
        apply_reset();
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        checks++; if (bus2.rom_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr_op got %0h exp ff", bus2.rom_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus2.rom_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr_imm got %0h exp 00", bus2.rom_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus2.din !== 16'h2C00) begin errors++; $display("FAIL wrap_din_b0 got %0h exp 2c00", bus2.din); end
        @(negedge clk);
        checks++; if (bus2.din !== 16'h1234) begin errors++; $display("FAIL wrap_din_b1 got %0h exp 1234", bus2.din); end
        @(negedge clk);
        checks++; if (bus2.pc !== 8'h01) begin errors++; $display("FAIL wrap_pc got %0h exp 01", bus2.pc); end
        n = 0;
        while (bus2.halted !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus2.halted !== 1'b1 || bus2.pc !== 8'h01) begin errors++; $display("FAIL wrap_halt halted %0h pc %0h exp 1 01", bus2.halted, bus2.pc); end
    endtask

    task automatic test_reset_in_exec();
        int lat, rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h4040;
        done_beat = 3;
        apply_reset();
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL rst_exec_pre_run got %0h exp 1", bus.run); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL rst_exec_run got %0h exp 0", bus.run); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_exec_pc got %0h exp 00", bus.pc); end
        checks++; if (bus.din !== 16'h0000) begin errors++; $display("FAIL rst_exec_din got %0h exp 0000", bus.din); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.run !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL rst_exec_idle run %0h halted %0h exp 0 0", bus.run, bus.halted); end
        rom[0] = 16'h0040;
        rom[1] = 16'hE000;
        done_beat = 1;
        start_pulse();
        step_until_pc(8'h01, 20, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_exec_refetch_lat got %0d exp 4", lat); end
        checks++; if (din_log[0] !== 16'h0040) begin errors++; $display("FAIL rst_exec_refetch_din got %0h exp 0040", din_log[0]); end
        run_to_halt(20, rc, ok);
        checks++; if (ok !== 1'b1 || bus.pc !== 8'h01) begin errors++; $display("FAIL rst_exec_halt ok %0h pc %0h exp 1 01", ok, bus.pc); end
    endtask

    task automatic test_back_to_back();
        int rc;
        bit ok;
        clear_roms();
        rom[0] = 16'h0040;
        rom[1] = 16'h2800;
        rom[2] = 16'h5A5A;
        rom[3] = 16'h6040;
        rom[4] = 16'hE000;
        done_beat = 1;
        apply_reset();
        start_pulse();
        run_to_halt(60, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_halt got %0h exp 1", ok); end
        checks++; if (rc !== 6) begin errors++; $display("FAIL b2b_run_cycles got %0d exp 6", rc); end
        checks++; if (bus.pc !== 8'h04) begin errors++; $display("FAIL b2b_pc got %0h exp 04", bus.pc); end
        checks++; if (din_log[2] !== 16'h2800) begin errors++; $display("FAIL b2b_din2 got %0h exp 2800", din_log[2]); end
        checks++; if (din_log[3] !== 16'h5A5A) begin errors++; $display("FAIL b2b_din3 got %0h exp 5a5a", din_log[3]); end
        checks++; if (din_log[4] !== 16'h6040) begin errors++; $display("FAIL b2b_din4 got %0h exp 6040", din_log[4]); end
        checks++; if (regs[2] !== 16'h5A5A) begin errors++; $display("FAIL b2b_r2 got %0h exp 5a5a", regs[2]); end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        done_extra = 1'b0;
        done_beat  = 1;
        test_reset();
        test_mv();
        test_mvi();
        test_add_long();
        test_illegal();
        test_wrap();
        test_reset_in_exec();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
